// File: rtl/scope_fb_arbiter.sv
// scope_fb_arbiter: shares one single-port pixel RAM between scanout, draw and a full-frame clear engine
module scope_fb_arbiter #(
    parameter int H_SIZE = 640,
    parameter int V_SIZE = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              err_oob,
    output logic [15:0]       stall_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TOTAL = H_SIZE * V_SIZE;
    localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W+1)'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              scan_g;
    logic              clr_g;
    logic              draw_g;
    logic              oob;

    // grant selection: scanout first, then clear, then draw; the RAM port holds its last address when idle
    always_comb begin
        scan_g    = !reset && scan_req;
        wr_ready  = !reset && state == IDLE && !scan_req;
        draw_g    = wr_ready && wr_valid;
        clr_g     = !reset && state == CLEAR && !scan_req;
        oob       = {1'b0, wr_addr} >= TOTAL_W;
        clr_done  = clr_g && clr_addr == LAST;
        clr_busy  = state == CLEAR;
        mem_we    = clr_g || (draw_g && !oob);
        mem_addr  = reset ? '0 : scan_g ? scan_addr : clr_g ? clr_addr : draw_g ? wr_addr : addr_q;
        mem_wdata = reset ? '0 : clr_g ? CLEAR_COLOUR : draw_g ? wr_data : wdata_q;
        scan_data = scan_valid ? mem_rdata : rdata_q;
    end

    // held RAM port values, scan return path, sticky error and stall counter
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            scan_valid <= 1'b0;
            err_oob    <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            scan_valid <= scan_g;
            if (scan_valid) rdata_q <= mem_rdata;
            if (draw_g && oob) err_oob <= 1'b1;
            if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // clear engine: walks clr_addr over the frame, only advancing on cycles it actually owns the RAM
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else if (state == IDLE) begin
            if (clr_start) begin
                state    <= CLEAR;
                clr_addr <= '0;
            end
        end else if (clr_g) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_done) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_scope_fb_arbiter.sv
// tb_scope_fb_arbiter: directed vectors for the frame-buffer arbiter on a 16x8 frame
module tb_scope_fb_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam logic [7:0] CC = 8'h0F;

    logic          clock = 1'b0;
    logic          reset;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          err_oob;
    logic [15:0]   stall_cnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [7:0] ram [256];
    logic       preload;
    int         n_vec = 0;
    int         n_bad = 0;
    int         excl = 0;

    scope_fb_arbiter #(.H_SIZE(16), .V_SIZE(8), .ADDR_W(AW), .DATA_W(DW), .CLEAR_COLOUR(CC)) dut (
        .clock(clock), .reset(reset),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .err_oob(err_oob), .stall_cnt(stall_cnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // synchronous single-port RAM, preloaded with pixel = address
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // a write while scanout owns the port would be a double grant
    always @(negedge clock) if (mem_we && scan_req) excl++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_clear(input bit toggle, output int busy, output int scans, output int dones,
                             output int done_addr);
        busy = 0;
        scans = 0;
        dones = 0;
        done_addr = -1;
        step();
        clr_start = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 1000; k++) begin
            step();
            scan_req = toggle && (k % 2 == 0);
            scan_addr = 8'd1;
            clr_start = (k == 10);
            @(negedge clock);
            if (!clr_busy) break;
            busy++;
            if (scan_req) scans++;
            if (clr_done) begin
                dones++;
                done_addr = int'(mem_addr);
            end
        end
        scan_req = 1'b0;
        clr_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int stalls, busy, scans, dones, done_addr, bad_words;
        reset = 1'b1;
        preload = 1'b1;
        scan_req = 1'b0;
        scan_addr = '0;
        wr_valid = 1'b1;
        wr_addr = 8'd5;
        wr_data = 8'h11;
        clr_start = 1'b0;
        step();
        preload = 1'b0;
        @(negedge clock);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        step();
        reset = 1'b0;
        wr_valid = 1'b0;
        @(negedge clock);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_scan_data", scan_data, 0);
        chk("rst_err_oob", err_oob, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_addr_idle", mem_addr, 0);

        for (int i = 0; i <= 10; i++) begin
            step();
            scan_req = (i < 10);
            scan_addr = 8'(i);
            @(negedge clock);
            chk("scan_valid", scan_valid, i > 0);
            if (i > 0) chk("scan_data", scan_data, i - 1);
            if (i < 10) chk("scan_addr_out", mem_addr, i);
        end

        step();
        scan_req = 1'b0;
        wr_valid = 1'b1;
        wr_addr = 8'd100;
        wr_data = 8'hA5;
        @(negedge clock);
        chk("draw_ready", wr_ready, 1);
        chk("draw_we", mem_we, 1);
        chk("draw_addr", mem_addr, 100);
        chk("draw_wdata", mem_wdata, 8'hA5);
        step();
        wr_valid = 1'b0;
        scan_req = 1'b1;
        scan_addr = 8'd100;
        @(negedge clock);
        chk("readback_we", mem_we, 0);
        step();
        scan_req = 1'b0;
        @(negedge clock);
        chk("readback_valid", scan_valid, 1);
        chk("readback_data", scan_data, 8'hA5);
        chk("hold_addr", mem_addr, 100);
        chk("hold_we", mem_we, 0);

        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            scan_req = 1'b1;
            scan_addr = 8'd3;
            wr_valid = 1'b1;
            wr_addr = 8'd7;
            wr_data = 8'h3C;
            @(negedge clock);
            if (!wr_ready) stalls++;
        end
        chk("stall_ready_low", stalls, 20);
        step();
        scan_req = 1'b0;
        @(negedge clock);
        chk("stall_release_ready", wr_ready, 1);
        chk("stall_release_we", mem_we, 1);
        chk("stall_release_addr", mem_addr, 7);
        chk("stall_cnt", stall_cnt, 20);
        step();
        wr_valid = 1'b0;
        @(negedge clock);
        chk("stall_cnt_hold", stall_cnt, 20);
        chk("stall_write_landed", ram[7], 8'h3C);

        run_clear(1'b0, busy, scans, dones, done_addr);
        chk("clear_busy_cycles", busy, 128);
        chk("clear_done_pulses", dones, 1);
        chk("clear_done_addr", done_addr, 127);
        bad_words = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== CC) bad_words++;
        chk("clear_words_wrong", bad_words, 0);
        chk("clear_beyond_frame", ram[128], 8'd128);

        run_clear(1'b1, busy, scans, dones, done_addr);
        chk("clear_scan_busy_cycles", busy, 256);
        chk("clear_scan_cycles", scans, 128);
        chk("clear_scan_done_pulses", dones, 1);
        chk("clear_scan_done_addr", done_addr, 127);

        step();
        wr_valid = 1'b1;
        wr_addr = 8'd128;
        wr_data = 8'h55;
        @(negedge clock);
        chk("oob_ready", wr_ready, 1);
        chk("oob_we", mem_we, 0);
        chk("oob_before", err_oob, 0);
        step();
        wr_valid = 1'b0;
        @(negedge clock);
        chk("oob_set", err_oob, 1);
        step();
        step();
        step();
        @(negedge clock);
        chk("oob_sticky", err_oob, 1);
        chk("oob_ram_untouched", ram[128], 8'd128);

        step();
        wr_valid = 1'b1;
        wr_addr = 8'd20;
        wr_data = 8'h77;
        clr_start = 1'b1;
        @(negedge clock);
        chk("draw_clr_we", mem_we, 1);
        chk("draw_clr_addr", mem_addr, 20);
        chk("draw_clr_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        clr_start = 1'b0;
        @(negedge clock);
        chk("draw_clr_landed", ram[20], 8'h77);
        chk("draw_clr_busy", clr_busy, 1);
        chk("draw_clr_first_addr", mem_addr, 0);
        chk("draw_clr_first_we", mem_we, 1);
        chk("draw_clr_first_wdata", mem_wdata, CC);
        for (int k = 1; k < 50; k++) step();
        @(negedge clock);
        chk("abort_pre_addr", mem_addr, 49);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("abort_no_done", clr_done, 0);
        chk("abort_we", mem_we, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", clr_busy, 0);
        chk("abort_ready", wr_ready, 1);
        chk("abort_oob_cleared", err_oob, 0);
        chk("abort_partial", ram[100], CC);
        step();
        clr_start = 1'b1;
        @(negedge clock);
        step();
        clr_start = 1'b0;
        @(negedge clock);
        chk("restart_busy", clr_busy, 1);
        chk("restart_addr", mem_addr, 0);
        chk("restart_we", mem_we, 1);
        chk("no_double_grant", excl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
